// File: rtl/icache_arbiter.sv
// -----------------------------------------------------------------------------
// icache_arbiter
//   Shares one instruction-cache port between two fetch requesters (r0, r1).
//   Requests are arbitrated round-robin (or fixed priority to r0), and the
//   owner of every accepted request is queued in a small owner FIFO so that
//   in-order icache responses can be routed back to the requester that asked.
//
// Handshake semantics (all request/response channels):
//   A transfer happens on a rising clk_i edge where valid and ready are both 1.
//   A source that raises valid holds it, and its payload, stable until the
//   transfer happens. Ready may depend combinationally on valid; valid never
//   depends on ready.
//
// Ports
//   clk_i, rst_ni                  CPU clock, asynchronous active-low reset
//   rN_req_addr_i/valid_i/ready_o  requester N fetch request channel
//   rN_resp_addr_o/data_o/valid_o  requester N response channel
//   rN_resp_ready_i                requester N accepts the response
//   ic_req_addr_o/valid_o/ready_i  request channel towards the icache
//   ic_resp_addr_i/data_i/valid_i  response channel from the icache
//   ic_resp_ready_o                arbiter accepts the icache response
//   outstanding_o                  owner FIFO occupancy
//   err_o                          sticky: response arrived with no owner
//   rN_grants_o                    accepted-request counters per requester
//
// Build option
//   ICACHE_ARB_STATS_EN            when defined, rN_grants_o count accepted
//                                  requests (saturating); otherwise tied to 0.
// -----------------------------------------------------------------------------
package icache_arbiter_pkg;
  typedef logic [31:0] memaddr_t;
  typedef logic [31:0] word_t;
endpackage

module icache_arbiter
  import icache_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  memaddr_t                 r0_req_addr_i,
  input  logic                     r0_req_valid_i,
  output logic                     r0_req_ready_o,
  input  memaddr_t                 r1_req_addr_i,
  input  logic                     r1_req_valid_i,
  output logic                     r1_req_ready_o,
  output memaddr_t                 r0_resp_addr_o,
  output word_t                    r0_resp_data_o,
  output logic                     r0_resp_valid_o,
  input  logic                     r0_resp_ready_i,
  output memaddr_t                 r1_resp_addr_o,
  output word_t                    r1_resp_data_o,
  output logic                     r1_resp_valid_o,
  input  logic                     r1_resp_ready_i,
  output memaddr_t                 ic_req_addr_o,
  output logic                     ic_req_valid_o,
  input  logic                     ic_req_ready_i,
  input  memaddr_t                 ic_resp_addr_i,
  input  word_t                    ic_resp_data_i,
  input  logic                     ic_resp_valid_i,
  output logic                     ic_resp_ready_o,
  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic                     err_o,
  output logic [31:0]              r0_grants_o,
  output logic [31:0]              r1_grants_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;   // requester held while LOCKED
  logic            last_q;             // requester granted most recently
  logic            sel;                // requester currently presented
  logic            sel_valid;
  logic            accept;
  logic            pop;
  logic            drop;
  logic            full, empty;
  logic            head;
  logic            err_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            fifo_q [DEPTH];

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = fifo_q[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Arbitration and request path
  // ---------------------------------------------------------------------------
  always_comb begin
    sel = 1'b0;
    if (state_q == LOCKED) begin
      sel = owner_q;
    end else if (!FIXED_PRIO && r0_req_valid_i && r1_req_valid_i) begin
      sel = ~last_q;
    end else if (r0_req_valid_i) begin
      sel = 1'b0;
    end else if (r1_req_valid_i) begin
      sel = 1'b1;
    end
  end

  assign sel_valid      = sel ? r1_req_valid_i : r0_req_valid_i;
  // A full FIFO blocks the request outright, even when a pop happens in the
  // same cycle, so a freed slot is only reusable one cycle later.
  assign ic_req_valid_o = rst_ni && sel_valid && !full;
  assign ic_req_addr_o  = sel ? r1_req_addr_i : r0_req_addr_i;
  assign r0_req_ready_o = rst_ni && ic_req_ready_i && !sel && !full;
  assign r1_req_ready_o = rst_ni && ic_req_ready_i &&  sel && !full;
  assign accept         = ic_req_valid_o && ic_req_ready_i;

  // ---------------------------------------------------------------------------
  // Owner-lock FSM: once a request is offered and stalled, its owner is held
  // until the icache takes it, so the address never changes under a stall.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (ic_req_valid_o && !ic_req_ready_i) begin
          state_d = LOCKED;
          owner_d = sel;
        end
      end
      LOCKED: begin
        if (accept) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;   // r0 wins the first tie after reset
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      if (accept) begin
        last_q <= sel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing. With no owner queued, responses are swallowed and
  // flagged rather than back-pressured, so a confused icache cannot hang.
  // ---------------------------------------------------------------------------
  assign r0_resp_addr_o = ic_resp_addr_i;
  assign r0_resp_data_o = ic_resp_data_i;
  assign r1_resp_addr_o = ic_resp_addr_i;
  assign r1_resp_data_o = ic_resp_data_i;

  always_comb begin
    r0_resp_valid_o = 1'b0;
    r1_resp_valid_o = 1'b0;
    ic_resp_ready_o = 1'b0;
    if (rst_ni) begin
      if (empty) begin
        ic_resp_ready_o = 1'b1;
      end else begin
        r0_resp_valid_o = ic_resp_valid_i && !head;
        r1_resp_valid_o = ic_resp_valid_i &&  head;
        ic_resp_ready_o = head ? r1_resp_ready_i : r0_resp_ready_i;
      end
    end
  end

  assign pop  = ic_resp_valid_i && ic_resp_ready_o && !empty;
  assign drop = ic_resp_valid_i && ic_resp_ready_o &&  empty;

  // ---------------------------------------------------------------------------
  // Owner FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        err_q <= 1'b1;
      end
    end
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;

  // ---------------------------------------------------------------------------
  // Grant statistics
  // ---------------------------------------------------------------------------
`ifdef ICACHE_ARB_STATS_EN
  logic [31:0] grants0_q, grants1_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grants0_q <= '0;
      grants1_q <= '0;
    end else if (accept) begin
      if (!sel && grants0_q != 32'hFFFF_FFFF) begin
        grants0_q <= grants0_q + 32'd1;
      end
      if (sel && grants1_q != 32'hFFFF_FFFF) begin
        grants1_q <= grants1_q + 32'd1;
      end
    end
  end

  assign r0_grants_o = grants0_q;
  assign r1_grants_o = grants1_q;
`else
  assign r0_grants_o = '0;
  assign r1_grants_o = '0;
`endif

endmodule

// File: tb/tb_icache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_icache_arbiter
//   Directed bench for icache_arbiter (DEPTH=4, round-robin). A queue-based
//   model of the owner FIFO and arbitration rules predicts every output each
//   cycle; a few literal expectations pin key scenarios.
// -----------------------------------------------------------------------------
module tb_icache_arbiter;
  import icache_arbiter_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- DUT signals ----------------
  memaddr_t    r0_req_addr_i, r1_req_addr_i;
  logic        r0_req_valid_i, r1_req_valid_i;
  logic        r0_req_ready_o, r1_req_ready_o;
  memaddr_t    r0_resp_addr_o, r1_resp_addr_o;
  word_t       r0_resp_data_o, r1_resp_data_o;
  logic        r0_resp_valid_o, r1_resp_valid_o;
  logic        r0_resp_ready_i, r1_resp_ready_i;
  memaddr_t    ic_req_addr_o;
  logic        ic_req_valid_o, ic_req_ready_i;
  memaddr_t    ic_resp_addr_i;
  word_t       ic_resp_data_i;
  logic        ic_resp_valid_i, ic_resp_ready_o;
  logic [2:0]  outstanding_o;
  logic        err_o;
  logic [31:0] r0_grants_o, r1_grants_o;

  icache_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .r0_req_addr_i(r0_req_addr_i), .r0_req_valid_i(r0_req_valid_i), .r0_req_ready_o(r0_req_ready_o),
    .r1_req_addr_i(r1_req_addr_i), .r1_req_valid_i(r1_req_valid_i), .r1_req_ready_o(r1_req_ready_o),
    .r0_resp_addr_o(r0_resp_addr_o), .r0_resp_data_o(r0_resp_data_o),
    .r0_resp_valid_o(r0_resp_valid_o), .r0_resp_ready_i(r0_resp_ready_i),
    .r1_resp_addr_o(r1_resp_addr_o), .r1_resp_data_o(r1_resp_data_o),
    .r1_resp_valid_o(r1_resp_valid_o), .r1_resp_ready_i(r1_resp_ready_i),
    .ic_req_addr_o(ic_req_addr_o), .ic_req_valid_o(ic_req_valid_o), .ic_req_ready_i(ic_req_ready_i),
    .ic_resp_addr_i(ic_resp_addr_i), .ic_resp_data_i(ic_resp_data_i),
    .ic_resp_valid_i(ic_resp_valid_i), .ic_resp_ready_o(ic_resp_ready_o),
    .outstanding_o(outstanding_o), .err_o(err_o),
    .r0_grants_o(r0_grants_o), .r1_grants_o(r1_grants_o)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_q[$];          // owners of outstanding requests, oldest first
  int          m_last = 1;      // last granted requester
  int          m_lock = -1;     // requester held by a stalled request, -1 none
  bit          m_err  = 1'b0;
  logic [31:0] m_g [2] = '{32'd0, 32'd0};
  int          grant_log[$];
  int          resp_who[$];
  logic [31:0] resp_addr[$];

  function automatic logic [31:0] exp_grants(input int n);
`ifdef ICACHE_ARB_STATS_EN
    return m_g[n];
`else
    return 32'd0;
`endif
  endfunction

  always @(negedge clk_i) begin : monitor
    int   sel;
    int   h;
    bit   full, empty, vreq, e_icv, acc, e_rv0, e_rv1, e_rr;
    if (!rst_ni) begin
      chk("rst_ic_req_valid", ic_req_valid_o, 0);
      chk("rst_r0_req_ready", r0_req_ready_o, 0);
      chk("rst_r1_req_ready", r1_req_ready_o, 0);
      chk("rst_r0_resp_valid", r0_resp_valid_o, 0);
      chk("rst_r1_resp_valid", r1_resp_valid_o, 0);
      chk("rst_ic_resp_ready", ic_resp_ready_o, 0);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_r0_grants", r0_grants_o, 0);
      chk("rst_r1_grants", r1_grants_o, 0);
      m_q.delete();
      m_last = 1;
      m_lock = -1;
      m_err  = 1'b0;
      m_g[0] = 32'd0;
      m_g[1] = 32'd0;
    end else begin
      full  = (m_q.size() == DEPTH);
      empty = (m_q.size() == 0);
      if (m_lock >= 0)                          sel = m_lock;
      else if (r0_req_valid_i && r1_req_valid_i) sel = 1 - m_last;
      else if (r1_req_valid_i)                   sel = 1;
      else                                       sel = 0;
      vreq  = (sel == 1) ? r1_req_valid_i : r0_req_valid_i;
      e_icv = vreq && !full;

      chk("ic_req_valid", ic_req_valid_o, e_icv);
      if (e_icv) chk("ic_req_addr", ic_req_addr_o, (sel == 1) ? r1_req_addr_i : r0_req_addr_i);
      chk("r0_req_ready", r0_req_ready_o, ic_req_ready_i && sel == 0 && !full);
      chk("r1_req_ready", r1_req_ready_o, ic_req_ready_i && sel == 1 && !full);
      chk("r0_resp_addr", r0_resp_addr_o, ic_resp_addr_i);
      chk("r1_resp_addr", r1_resp_addr_o, ic_resp_addr_i);
      chk("r0_resp_data", r0_resp_data_o, ic_resp_data_i);
      chk("r1_resp_data", r1_resp_data_o, ic_resp_data_i);

      h = empty ? 0 : m_q[0];
      e_rv0 = !empty && ic_resp_valid_i && h == 0;
      e_rv1 = !empty && ic_resp_valid_i && h == 1;
      e_rr  = empty ? 1'b1 : ((h == 1) ? r1_resp_ready_i : r0_resp_ready_i);
      chk("r0_resp_valid", r0_resp_valid_o, e_rv0);
      chk("r1_resp_valid", r1_resp_valid_o, e_rv1);
      chk("ic_resp_ready", ic_resp_ready_o, e_rr);
      chk("outstanding", outstanding_o, m_q.size());
      chk("err", err_o, m_err);
      chk("r0_grants", r0_grants_o, exp_grants(0));
      chk("r1_grants", r1_grants_o, exp_grants(1));

      // advance the model across the coming edge
      acc = e_icv && ic_req_ready_i;
      if (e_icv && !ic_req_ready_i) m_lock = sel;
      if (acc) m_lock = -1;
      if (!empty && ic_resp_valid_i && e_rr) begin
        resp_who.push_back(h);
        resp_addr.push_back(ic_resp_addr_i);
        void'(m_q.pop_front());
      end
      if (empty && ic_resp_valid_i) m_err = 1'b1;
      if (acc) begin
        m_q.push_back(sel);
        m_last = sel;
        grant_log.push_back(sel);
        if (m_g[sel] != 32'hFFFF_FFFF) m_g[sel] = m_g[sel] + 32'd1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain(input int n);
    ic_resp_valid_i = 1'b1;
    r0_resp_ready_i = 1'b1;
    r1_resp_ready_i = 1'b1;
    repeat (n) begin
      ic_resp_addr_i = $urandom_range(32'h0000_0FFF, 0);
      ic_resp_data_i = $urandom;
      tick();
    end
    ic_resp_valid_i = 1'b0;
    r0_resp_ready_i = 1'b0;
    r1_resp_ready_i = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    r0_req_addr_i = '0; r0_req_valid_i = 0;
    r1_req_addr_i = '0; r1_req_valid_i = 0;
    r0_resp_ready_i = 0; r1_resp_ready_i = 0;
    ic_req_ready_i = 0; ic_resp_addr_i = '0; ic_resp_data_i = '0; ic_resp_valid_i = 0;

    // Reset with live inputs: outputs must still be quiet.
    rst_ni = 1'b0;
    r0_req_valid_i = 1; ic_req_ready_i = 1; ic_resp_valid_i = 1;
    repeat (3) tick();
    r0_req_valid_i = 0; ic_req_ready_i = 0; ic_resp_valid_i = 0;
    tick();
    rst_ni = 1'b1;
    tick();

    // Round-robin alternation, first grant to r0.
    r0_req_addr_i = 32'h10; r0_req_valid_i = 1;
    r1_req_addr_i = 32'h20; r1_req_valid_i = 1;
    ic_req_ready_i = 1;
    repeat (4) tick();
    r0_req_valid_i = 0; r1_req_valid_i = 0;
    @(negedge clk_i);
    chk("rr_outstanding_4", outstanding_o, 4);
    chk("rr_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("rr_grant_order", grant_log[i], exp_order[i]);
    tick();
    drain(4);

    // Owner lock: r0 stalls, r1 arrives with r1 holding round-robin priority.
    r0_req_addr_i = 32'h80; r0_req_valid_i = 1;
    tick();
    r0_req_addr_i = 32'h200; ic_req_ready_i = 0;
    tick();
    r1_req_addr_i = 32'h300; r1_req_valid_i = 1;
    repeat (2) begin
      @(negedge clk_i);
      chk("lock_addr_stall", ic_req_addr_o, 32'h200);
      tick();
    end
    ic_req_ready_i = 1;
    @(negedge clk_i);
    chk("lock_addr_hs", ic_req_addr_o, 32'h200);
    chk("lock_r0_ready", r0_req_ready_o, 1);
    chk("lock_r1_ready", r1_req_ready_o, 0);
    tick();
    r0_req_valid_i = 0;
    tick();
    r1_req_valid_i = 0;
    drain(3);

    // FIFO full: no push-through on a same-cycle pop.
    r0_req_addr_i = 32'h400; r0_req_valid_i = 1;
    repeat (4) tick();
    @(negedge clk_i);
    chk("full_outstanding", outstanding_o, 4);
    chk("full_ic_valid", ic_req_valid_o, 0);
    chk("full_r0_ready", r0_req_ready_o, 0);
    tick();
    ic_resp_valid_i = 1; r0_resp_ready_i = 1;
    @(negedge clk_i);
    chk("full_pop_ic_valid", ic_req_valid_o, 0);
    tick();
    ic_resp_valid_i = 0; r0_resp_ready_i = 0;
    @(negedge clk_i);
    chk("after_pop_ic_valid", ic_req_valid_o, 1);
    chk("after_pop_outstanding", outstanding_o, 3);
    tick();
    r0_req_valid_i = 0;
    drain(4);

    // Response routing: r1 A=0x100, then r0 B=0x104.
    r1_req_addr_i = 32'h100; r1_req_valid_i = 1;
    tick();
    r1_req_valid_i = 0;
    r0_req_addr_i = 32'h104; r0_req_valid_i = 1;
    tick();
    r0_req_valid_i = 0;
    ic_resp_valid_i = 1; ic_resp_addr_i = 32'h100; ic_resp_data_i = 32'hAAAA_0100;
    r1_resp_ready_i = 1; r0_resp_ready_i = 0;
    @(negedge clk_i);
    chk("route_a_r1_valid", r1_resp_valid_o, 1);
    chk("route_a_r0_valid", r0_resp_valid_o, 0);
    tick();
    ic_resp_addr_i = 32'h104; ic_resp_data_i = 32'hBBBB_0104;
    repeat (2) begin
      @(negedge clk_i);
      chk("route_b_r0_valid", r0_resp_valid_o, 1);
      chk("route_b_r1_valid", r1_resp_valid_o, 0);
      chk("route_b_stall", ic_resp_ready_o, 0);
      tick();
    end
    r0_resp_ready_i = 1;
    @(negedge clk_i);
    chk("route_b_ready", ic_resp_ready_o, 1);
    tick();
    ic_resp_valid_i = 0; r0_resp_ready_i = 0; r1_resp_ready_i = 0;
    chk("route_log_len", (resp_who.size() >= 2) ? 1 : 0, 1);
    if (resp_who.size() >= 2) begin
      chk("route_a_who", resp_who[resp_who.size()-2], 1);
      chk("route_a_addr", resp_addr[resp_addr.size()-2], 32'h100);
      chk("route_b_who", resp_who[resp_who.size()-1], 0);
      chk("route_b_addr", resp_addr[resp_addr.size()-1], 32'h104);
    end

    // Stray response with empty FIFO: swallowed, sticky error until reset.
    ic_resp_valid_i = 1;
    @(negedge clk_i);
    chk("stray_ready", ic_resp_ready_o, 1);
    tick();
    ic_resp_valid_i = 0;
    repeat (3) begin
      @(negedge clk_i);
      chk("stray_err_held", err_o, 1);
      tick();
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("stray_err_cleared", err_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Grant counters: 5 accepts for r0, 3 for r1.
    r0_req_valid_i = 1; r1_req_valid_i = 1;
    repeat (4) tick();
    r0_req_valid_i = 0; r1_req_valid_i = 0;
    drain(4);
    r0_req_valid_i = 1; r1_req_valid_i = 1;
    repeat (2) tick();
    r0_req_valid_i = 0; r1_req_valid_i = 0;
    drain(2);
    r0_req_valid_i = 1;
    repeat (2) tick();
    r0_req_valid_i = 0;
    drain(2);
    @(negedge clk_i);
`ifdef ICACHE_ARB_STATS_EN
    chk("grants_r0", r0_grants_o, 5);
    chk("grants_r1", r1_grants_o, 3);
`else
    chk("grants_r0", r0_grants_o, 0);
    chk("grants_r1", r1_grants_o, 0);
`endif
    tick();

    // Reset mid-transaction: the lost owner turns its response into an error.
    r0_req_addr_i = 32'h500; r0_req_valid_i = 1;
    tick();
    r0_req_valid_i = 0;
    @(negedge clk_i);
    chk("mid_outstanding", outstanding_o, 1);
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    ic_resp_valid_i = 1; r0_resp_ready_i = 1;
    @(negedge clk_i);
    chk("mid_resp_ready", ic_resp_ready_o, 1);
    chk("mid_r0_resp_valid", r0_resp_valid_o, 0);
    tick();
    ic_resp_valid_i = 0; r0_resp_ready_i = 0;
    @(negedge clk_i);
    chk("mid_err", err_o, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_arbiter.md
ICACHE_ARBITER -- requirements
Module: icache_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4: owner-FIFO depth, i.e. max outstanding icache requests (power of 2, 2..16).
REQ-002 SHALL have parameter FIXED_PRIO, default 0: 0 selects round-robin, 1 gives requester 0 absolute priority.
REQ-003 SHALL have ports, one per line:
- clk_i  in  1  CPU clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- r0_req_addr_i / r1_req_addr_i  in  memaddr_t  requester fetch address.
- r0_req_valid_i / r1_req_valid_i  in  1  request valid.
- r0_req_ready_o / r1_req_ready_o  out  1  request accepted.
- r0_resp_addr_o / r1_resp_addr_o  out  memaddr_t  routed response address.
- r0_resp_data_o / r1_resp_data_o  out  word_t (32)  routed response data.
- r0_resp_valid_o / r1_resp_valid_o  out  1  response valid.
- r0_resp_ready_i / r1_resp_ready_i  in  1  requester accepts response.
- ic_req_addr_o  out  memaddr_t  to icache.
- ic_req_valid_o  out  1  to icache.
- ic_req_ready_i  in  1  from icache.
- ic_resp_addr_i  in  memaddr_t  from icache.
- ic_resp_data_i  in  word_t  from icache.
- ic_resp_valid_i  in  1  from icache.
- ic_resp_ready_o  out  1  to icache.
- outstanding_o  out  $clog2(DEPTH)+1  owner-FIFO occupancy.
- err_o  out  1  sticky: icache response with empty owner FIFO.
- r0_grants_o / r1_grants_o  out  32  accepted-request counters (see Configuration).

Function
REQ-004 SHALL use states IDLE and LOCKED; IDLE selects a requester, LOCKED holds it.
REQ-005 IDLE: selection combinational; ic_req_valid_o = selected valid AND owner FIFO not full; ic_req_addr_o = selected addr.
REQ-006 Round-robin: both valid -> grant the requester not granted last; last-grant pointer updates only on an accepted icache handshake. FIXED_PRIO=1 -> requester 0 always wins.
REQ-007 IDLE, ic_req_valid_o=1, ic_req_ready_i=0 -> LOCKED with owner latched; LOCKED never switches owner, even if the other requester asserts valid.
REQ-008 LOCKED -> IDLE on ic_req_valid_o && ic_req_ready_i.
REQ-009 rN_req_ready_o = ic_req_ready_i AND owner==N AND FIFO not full; zero-cycle pass-through, no added latency.
REQ-010 Every accepted icache request pushes owner ID into the FIFO the same edge.
REQ-011 FIFO full: ic_req_valid_o=0, both req_ready=0, even if a pop occurs the same cycle (no push-through).
REQ-012 Response routing: head owner's resp_valid_o = ic_resp_valid_i, other's = 0; both resp_addr/data_o driven from ic_resp_* unconditionally.
REQ-013 ic_resp_ready_o = head owner's resp_ready_i; FIFO pops on ic_resp_valid_i && ic_resp_ready_o.
REQ-014 Simultaneous push and pop when not full: occupancy unchanged, order preserved.
REQ-015 FIFO empty and ic_resp_valid_i=1: ic_resp_ready_o=1 (drop), no pop, err_o set until reset.
REQ-016 Response order matches request order; arbiter assumes in-order icache.

Reset
REQ-017 rst_ni low SHALL asynchronously force state IDLE, last-grant pointer to requester 1 (so requester 0 wins first tie), FIFO empty, outstanding_o=0, err_o=0, counters=0.
REQ-018 While reset asserted all valid and ready outputs SHALL be 0; reset mid-transaction discards outstanding owners, later responses raise err_o.

Configuration
REQ-019 Macro ICACHE_ARB_STATS_EN defined: r0/r1_grants_o increment on each accepted request of that requester, saturating at 32'hFFFF_FFFF.
REQ-020 Macro undefined: counters not built, r0/r1_grants_o tied to 0; all other behaviour identical.

Verification
REQ-021 Both valid every cycle, ic ready always, FIFO drained -> grants alternate r0,r1,r0,r1; first grant r0.
REQ-022 r0 valid, ic_req_ready_i low 3 cycles, r1 asserts valid cycle 1 -> ic_req_addr_o stays r0 addr, r1_req_ready_o=0 until r0 handshake.
REQ-023 4 requests accepted (DEPTH=4), no responses -> outstanding_o=4, ic_req_valid_o=0; one response popped -> next request accepted following cycle.
REQ-024 Requests r1 A=0x100, r0 B=0x104; responses in order -> A delivered only on r1_resp_valid_o, B only on r0; r0_resp_ready_i=0 stalls ic_resp_ready_o.
REQ-025 ic_resp_valid_i pulsed with empty FIFO -> ic_resp_ready_o=1, err_o=1 and held; rst_ni low clears it.
REQ-026 ICACHE_ARB_STATS_EN defined, 5 r0 and 3 r1 accepts -> r0_grants_o=5, r1_grants_o=3; undefined -> both 0.
